// File: rtl/crypto_pkg.sv
// Shared definitions for the crypto register bank: bus-read states and default geometry.
package crypto_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_HOLD = 1'b1
    } rd_state_t;

endpackage

// File: rtl/crypto_reg_bank_if.sv
// Bus-side bundle of the register bank: write port with reject pulse, and a held read handshake.
interface crypto_reg_bank_if #(
    parameter int WIDTH  = crypto_pkg::DEF_WIDTH,
    parameter int ADDR_W = $clog2(crypto_pkg::DEF_DEPTH)
);
    logic              bus_wr_en;
    logic [ADDR_W-1:0] bus_wr_addr;
    logic [WIDTH-1:0]  bus_wr_data;
    logic              bus_wr_err;
    logic              bus_rd_req;
    logic [ADDR_W-1:0] bus_rd_addr;
    logic              bus_rd_ready;
    logic [WIDTH-1:0]  bus_rd_data;
    logic              bus_rd_valid;
    logic              bus_rd_ack;

    modport master (
        output bus_wr_en, bus_wr_addr, bus_wr_data, bus_rd_req, bus_rd_addr, bus_rd_ack,
        input  bus_wr_err, bus_rd_ready, bus_rd_data, bus_rd_valid
    );

    modport slave (
        input  bus_wr_en, bus_wr_addr, bus_wr_data, bus_rd_req, bus_rd_addr, bus_rd_ack,
        output bus_wr_err, bus_rd_ready, bus_rd_data, bus_rd_valid
    );
endinterface

// File: rtl/crypto_wr_arbiter.sv
// Combinational write arbitration: range and lock filtering, same-address priority, collision and reject flags.
module crypto_wr_arbiter
    import crypto_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int ADDR_W       = $clog2(DEF_DEPTH),
    parameter bit BUS_PRIORITY = 1'b1
) (
    input  logic              core_en,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              bus_en,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DEPTH-1:0]  lock,
    output logic              core_commit,
    output logic              bus_commit,
    output logic              collision,
    output logic              error
);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

    logic core_ok;
    logic bus_ok;
    logic bus_locked;
    logic same;

    always_comb begin
        bus_locked = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus_addr == ADDR_W'(i)) bus_locked = lock[i];
        end
        core_ok = core_en && ({1'b0, core_addr} < LIMIT);
        // A rejected bus write never competes, so the core write survives it untouched.
        bus_ok  = bus_en && ({1'b0, bus_addr} < LIMIT) && !bus_locked;
        same    = core_ok && bus_ok && (core_addr == bus_addr);
        core_commit = core_ok && !(same && BUS_PRIORITY);
        bus_commit  = bus_ok && !(same && !BUS_PRIORITY);
        collision   = same;
        error       = bus_en && !bus_ok;
    end
endmodule

// File: rtl/crypto_reg_bank.sv
// Dual-ported data register bank for the crypto core: arbitrated writes, bus write locks,
// registered core reads with optional write bypass, and a hold-until-ack bus read.
module crypto_reg_bank
    import crypto_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter bit BUS_PRIORITY = 1'b1,
    parameter bit BYPASS       = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_wr_en,
    input  logic [ADDR_W-1:0] core_wr_addr,
    input  logic [WIDTH-1:0]  core_wr_data,
    input  logic              core_rd_en,
    input  logic [ADDR_W-1:0] core_rd_addr,
    output logic [WIDTH-1:0]  core_rd_data,
    output logic              core_rd_valid,
    input  logic              core_lock_en,
    input  logic [ADDR_W-1:0] core_lock_addr,
    input  logic              core_lock_val,
    crypto_reg_bank_if.slave  bus,
    output logic              wr_collision
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] lock;

    logic core_commit;
    logic bus_commit;
    logic collision;
    logic error;

    logic [WIDTH-1:0] core_rd_next;
    logic [WIDTH-1:0] bus_rd_word;

    logic [WIDTH-1:0] rd_data_p1;
    logic             rd_vld_p1;
    logic             collision_p1;
    logic             err_p1;
    logic [WIDTH-1:0] hold_data;

    rd_state_t state_q;
    rd_state_t state_d;
    logic      capture;

    crypto_wr_arbiter #(
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .BUS_PRIORITY (BUS_PRIORITY)
    ) u_arbiter (
        .core_en     (core_wr_en),
        .core_addr   (core_wr_addr),
        .bus_en      (bus.bus_wr_en),
        .bus_addr    (bus.bus_wr_addr),
        .lock        (lock),
        .core_commit (core_commit),
        .bus_commit  (bus_commit),
        .collision   (collision),
        .error       (error)
    );

    // Out-of-range addresses match no entry and therefore read as zero.
    always_comb begin
        core_rd_next = '0;
        bus_rd_word  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (core_rd_addr == ADDR_W'(i)) core_rd_next = mem[i];
            if (bus.bus_rd_addr == ADDR_W'(i)) bus_rd_word = mem[i];
        end
        if (BYPASS) begin
            if (core_commit && (core_wr_addr == core_rd_addr)) core_rd_next = core_wr_data;
            if (bus_commit && (bus.bus_wr_addr == core_rd_addr)) core_rd_next = bus.bus_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            lock <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus_commit && (bus.bus_wr_addr == ADDR_W'(i))) mem[i] <= bus.bus_wr_data;
                else if (core_commit && (core_wr_addr == ADDR_W'(i))) mem[i] <= core_wr_data;
                if (core_lock_en && (core_lock_addr == ADDR_W'(i))) lock[i] <= core_lock_val;
            end
        end
    end

    // p0 -> p1: registered core read and write-status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_p1   <= '0;
            rd_vld_p1    <= 1'b0;
            collision_p1 <= 1'b0;
            err_p1       <= 1'b0;
        end else begin
            rd_vld_p1    <= core_rd_en;
            collision_p1 <= collision;
            err_p1       <= error;
            if (core_rd_en) rd_data_p1 <= core_rd_next;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (bus.bus_rd_req) begin
                    state_d = RD_HOLD;
                    capture = 1'b1;
                end
            end
            RD_HOLD: begin
                if (bus.bus_rd_ack) state_d = RD_IDLE;
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RD_IDLE;
            hold_data <= '0;
        end else begin
            state_q <= state_d;
            if (capture) hold_data <= bus_rd_word;
        end
    end

    assign core_rd_data     = rd_data_p1;
    assign core_rd_valid    = rd_vld_p1;
    assign wr_collision     = collision_p1;
    assign bus.bus_wr_err   = err_p1;
    assign bus.bus_rd_valid = (state_q == RD_HOLD);
    assign bus.bus_rd_ready = (state_q == RD_IDLE) && !rst;
    assign bus.bus_rd_data  = (state_q == RD_HOLD) ? hold_data : '0;
endmodule

// File: tb/tb_crypto_reg_bank.sv
// Scoreboard bench: two bank configurations share one randomized stimulus stream and are
// compared against an array-based model of the register bank behaviour.
`timescale 1ns/1ps
module tb_crypto_reg_bank;

    localparam int NI = 2;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        bit          cwe;
        logic [2:0]  cwa;
        logic [15:0] cwd;
        bit          cre;
        logic [2:0]  cra;
        bit          le;
        logic [2:0]  la;
        bit          lv;
        bit          bwe;
        logic [2:0]  bwa;
        logic [15:0] bwd;
        bit          brq;
        logic [2:0]  bra;
        bit          back;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_wr_en = 1'b0;
    logic [2:0]  core_wr_addr = '0;
    logic [15:0] core_wr_data = '0;
    logic        core_rd_en = 1'b0;
    logic [2:0]  core_rd_addr = '0;
    logic        core_lock_en = 1'b0;
    logic [2:0]  core_lock_addr = '0;
    logic        core_lock_val = 1'b0;
    logic        b_wr_en = 1'b0;
    logic [2:0]  b_wr_addr = '0;
    logic [15:0] b_wr_data = '0;
    logic        b_rd_req = 1'b0;
    logic [2:0]  b_rd_addr = '0;
    logic        b_rd_ack = 1'b0;

    logic [15:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic        coll_a, coll_b;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [15:0] m_mem  [NI][8];
    bit          m_lock [NI][8];
    bit          m_hold [NI];
    bit          prev_bv [NI];
    logic [15:0] held    [NI];

    exp_t q_core [NI][$];
    exp_t q_bus  [NI][$];
    int   q_coll [NI][$];
    int   q_err  [NI][$];
    int   q_rel  [NI][$];

    crypto_reg_bank_if #(.WIDTH(16), .ADDR_W(3)) bus_a ();
    crypto_reg_bank_if #(.WIDTH(16), .ADDR_W(3)) bus_b ();

    assign bus_a.bus_wr_en   = b_wr_en;
    assign bus_a.bus_wr_addr = b_wr_addr;
    assign bus_a.bus_wr_data = b_wr_data;
    assign bus_a.bus_rd_req  = b_rd_req;
    assign bus_a.bus_rd_addr = b_rd_addr;
    assign bus_a.bus_rd_ack  = b_rd_ack;
    assign bus_b.bus_wr_en   = b_wr_en;
    assign bus_b.bus_wr_addr = b_wr_addr;
    assign bus_b.bus_wr_data = b_wr_data;
    assign bus_b.bus_rd_req  = b_rd_req;
    assign bus_b.bus_rd_addr = b_rd_addr;
    assign bus_b.bus_rd_ack  = b_rd_ack;

    crypto_reg_bank #(
        .WIDTH(16), .DEPTH(8), .ADDR_W(3), .BUS_PRIORITY(1'b1), .BYPASS(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst),
        .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
        .core_rd_en(core_rd_en), .core_rd_addr(core_rd_addr),
        .core_rd_data(rd_data_a), .core_rd_valid(rd_valid_a),
        .core_lock_en(core_lock_en), .core_lock_addr(core_lock_addr), .core_lock_val(core_lock_val),
        .bus(bus_a.slave), .wr_collision(coll_a)
    );

    crypto_reg_bank #(
        .WIDTH(16), .DEPTH(6), .ADDR_W(3), .BUS_PRIORITY(1'b0), .BYPASS(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst),
        .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
        .core_rd_en(core_rd_en), .core_rd_addr(core_rd_addr),
        .core_rd_data(rd_data_b), .core_rd_valid(rd_valid_b),
        .core_lock_en(core_lock_en), .core_lock_addr(core_lock_addr), .core_lock_val(core_lock_val),
        .bus(bus_b.slave), .wr_collision(coll_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int depth_of(input int i);
        return (i == 0) ? 8 : 6;
    endfunction

    function automatic bit prio_of(input int i);
        return (i == 0);
    endfunction

    function automatic bit bypass_of(input int i);
        return (i == 1);
    endfunction

    task automatic cmp(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h cycle=%0d", name, i, act, exp, cyc);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // Reference: compute the post-edge contents of every register, then derive all responses.
    function automatic void model_step(input stim_t s);
        for (int i = 0; i < NI; i++) begin
            logic [15:0] nm [8];
            bit c_ok, b_ok, coll;
            exp_t e;
            int d;
            d    = depth_of(i);
            c_ok = s.cwe && (int'(s.cwa) < d);
            b_ok = s.bwe && (int'(s.bwa) < d) && !m_lock[i][s.bwa];
            coll = c_ok && b_ok && (s.cwa == s.bwa);
            for (int a = 0; a < 8; a++) nm[a] = m_mem[i][a];
            if (c_ok) nm[s.cwa] = s.cwd;
            if (b_ok) nm[s.bwa] = s.bwd;
            if (coll) nm[s.cwa] = prio_of(i) ? s.bwd : s.cwd;
            if (coll) q_coll[i].push_back(cyc + 1);
            if (s.bwe && !b_ok) q_err[i].push_back(cyc + 1);
            if (s.cre) begin
                e.due  = cyc + 1;
                e.data = (int'(s.cra) >= d) ? 16'h0 : (bypass_of(i) ? nm[s.cra] : m_mem[i][s.cra]);
                q_core[i].push_back(e);
            end
            if (m_hold[i]) begin
                if (s.back) begin
                    q_rel[i].push_back(cyc + 1);
                    m_hold[i] = 1'b0;
                end
            end else if (s.brq) begin
                e.due  = cyc + 1;
                e.data = (int'(s.bra) < d) ? m_mem[i][s.bra] : 16'h0;
                q_bus[i].push_back(e);
                m_hold[i] = 1'b1;
            end
            if (s.le && (int'(s.la) < d)) m_lock[i][s.la] = s.lv;
            for (int a = 0; a < 8; a++) m_mem[i][a] = nm[a];
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            if (m_hold[i]) q_rel[i].push_back(cyc);
            m_hold[i] = 1'b0;
            for (int a = 0; a < 8; a++) begin
                m_mem[i][a]  = 16'h0;
                m_lock[i][a] = 1'b0;
            end
        end
    endfunction

    task automatic drive(input stim_t s);
        @(posedge clk);
        #1;
        core_wr_en     = s.cwe;
        core_wr_addr   = s.cwa;
        core_wr_data   = s.cwd;
        core_rd_en     = s.cre;
        core_rd_addr   = s.cra;
        core_lock_en   = s.le;
        core_lock_addr = s.la;
        core_lock_val  = s.lv;
        b_wr_en        = s.bwe;
        b_wr_addr      = s.bwa;
        b_wr_data      = s.bwd;
        b_rd_req       = s.brq;
        b_rd_addr      = s.bra;
        b_rd_ack       = s.back;
        model_step(s);
    endtask

    task automatic check_inst(input int i, input logic cv, input logic [15:0] cd, input logic coll,
                              input logic err, input logic rdy, input logic bv, input logic [15:0] bd);
        exp_t e;
        int   due;
        if (cv) begin
            cmp("core_rd_expected", i, 32'(q_core[i].size() > 0), 32'd1);
            if (q_core[i].size() > 0) begin
                e = q_core[i].pop_front();
                cmp("core_rd_cycle", i, e.due, cyc);
                cmp("core_rd_data", i, 32'(cd), 32'(e.data));
            end
        end
        if (coll) begin
            cmp("collision_expected", i, 32'(q_coll[i].size() > 0), 32'd1);
            if (q_coll[i].size() > 0) begin
                due = q_coll[i].pop_front();
                cmp("collision_cycle", i, cyc, due);
            end
        end
        if (err) begin
            cmp("wr_err_expected", i, 32'(q_err[i].size() > 0), 32'd1);
            if (q_err[i].size() > 0) begin
                due = q_err[i].pop_front();
                cmp("wr_err_cycle", i, cyc, due);
            end
        end
        if (bv && !prev_bv[i]) begin
            cmp("bus_rd_expected", i, 32'(q_bus[i].size() > 0), 32'd1);
            if (q_bus[i].size() > 0) begin
                e = q_bus[i].pop_front();
                cmp("bus_rd_cycle", i, cyc, e.due);
                cmp("bus_rd_data", i, 32'(bd), 32'(e.data));
                held[i] = e.data;
            end
        end else if (bv) begin
            cmp("bus_rd_hold", i, 32'(bd), 32'(held[i]));
        end else if (prev_bv[i]) begin
            cmp("bus_rd_release_expected", i, 32'(q_rel[i].size() > 0), 32'd1);
            if (q_rel[i].size() > 0) begin
                due = q_rel[i].pop_front();
                cmp("bus_rd_release_cycle", i, cyc, due);
            end
        end
        if (rst) cmp("bus_rd_ready_in_reset", i, 32'(rdy), 32'd0);
        else     cmp("bus_rd_ready", i, 32'(rdy), 32'(!bv));
        prev_bv[i] = bv;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_inst(0, rd_valid_a, rd_data_a, coll_a, bus_a.bus_wr_err,
                       bus_a.bus_rd_ready, bus_a.bus_rd_valid, bus_a.bus_rd_data);
            check_inst(1, rd_valid_b, rd_data_b, coll_b, bus_b.bus_wr_err,
                       bus_b.bus_rd_ready, bus_b.bus_rd_valid, bus_b.bus_rd_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        for (int i = 0; i < NI; i++) begin
            prev_bv[i] = 1'b0;
            held[i]    = 16'h0;
        end
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        cmp("reset_core_rd_valid", 0, 32'(rd_valid_a), 32'd0);
        cmp("reset_core_rd_data", 1, 32'(rd_data_b), 32'd0);
        cmp("reset_collision", 0, 32'(coll_a | coll_b), 32'd0);
        cmp("reset_wr_err", 0, 32'(bus_a.bus_wr_err | bus_b.bus_wr_err), 32'd0);
        cmp("reset_bus_rd_valid", 0, 32'(bus_a.bus_rd_valid | bus_b.bus_rd_valid), 32'd0);
        cmp("reset_bus_rd_ready", 0, 32'(bus_a.bus_rd_ready | bus_b.bus_rd_ready), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        s = idle(); s.cwe = 1; s.cwa = 3'd3; s.cwd = 16'hBEEF; drive(s);
        s = idle(); s.cre = 1; s.cra = 3'd3; drive(s);
        drive(idle());

        s = idle(); s.cwe = 1; s.cwa = 3'd5; s.cwd = 16'h1111;
        s.bwe = 1; s.bwa = 3'd5; s.bwd = 16'h2222; drive(s);
        s = idle(); s.cre = 1; s.cra = 3'd5; drive(s);
        drive(idle());

        s = idle(); s.le = 1; s.la = 3'd2; s.lv = 1; drive(s);
        s = idle(); s.bwe = 1; s.bwa = 3'd2; s.bwd = 16'hAAAA; drive(s);
        s = idle(); s.cre = 1; s.cra = 3'd2; drive(s);
        s = idle(); s.le = 1; s.la = 3'd2; s.lv = 0; drive(s);
        s = idle(); s.bwe = 1; s.bwa = 3'd2; s.bwd = 16'hAAAA; drive(s);
        s = idle(); s.cre = 1; s.cra = 3'd2; drive(s);
        drive(idle());

        s = idle(); s.cwe = 1; s.cwa = 3'd1; s.cwd = 16'h00C3; drive(s);
        s = idle(); s.brq = 1; s.bra = 3'd1; drive(s);
        for (int k = 0; k < 5; k++) begin
            s = idle(); s.cwe = 1; s.cwa = 3'd1; s.cwd = 16'hFFFF; s.brq = 1; s.bra = 3'd4; drive(s);
        end
        s = idle(); s.back = 1; drive(s);
        drive(idle());
        drive(idle());

        s = idle(); s.bwe = 1; s.bwa = 3'd7; s.bwd = 16'h1234; drive(s);
        s = idle(); s.cre = 1; s.cra = 3'd7; drive(s);
        drive(idle());

        for (int n = 0; n < 400; n++) begin
            s.cwe  = 1'($urandom_range(0, 1));
            s.cwa  = 3'($urandom_range(0, 7));
            s.cwd  = 16'($urandom);
            s.cre  = 1'($urandom_range(0, 1));
            s.cra  = ($urandom_range(0, 2) == 0) ? s.cwa : 3'($urandom_range(0, 7));
            s.le   = ($urandom_range(0, 5) == 0);
            s.la   = 3'($urandom_range(0, 7));
            s.lv   = 1'($urandom_range(0, 1));
            s.bwe  = 1'($urandom_range(0, 1));
            s.bwa  = ($urandom_range(0, 3) == 0) ? s.cwa : 3'($urandom_range(0, 7));
            s.bwd  = 16'($urandom);
            s.brq  = ($urandom_range(0, 2) == 0);
            s.bra  = 3'($urandom_range(0, 7));
            s.back = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) s.bra = s.bwa;
            drive(s);
        end
        s = idle(); s.back = 1; drive(s);
        drive(idle());

        s = idle(); s.brq = 1; s.bra = 3'd3; drive(s);
        drive(idle());
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        cmp("reset_drops_valid", 0, 32'(bus_a.bus_rd_valid), 32'd0);
        cmp("reset_drops_valid", 1, 32'(bus_b.bus_rd_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            s = idle(); s.cre = 1; s.cra = 3'(a); drive(s);
        end
        s = idle(); s.brq = 1; s.bra = 3'd5; drive(s);
        s = idle(); s.back = 1; drive(s);
        repeat (3) drive(idle());
        @(negedge clk);
        #1;
        mon_en = 1'b0;

        for (int i = 0; i < NI; i++) begin
            cmp("core_rd_left", i, q_core[i].size(), 0);
            cmp("bus_rd_left", i, q_bus[i].size(), 0);
            cmp("collision_left", i, q_coll[i].size(), 0);
            cmp("wr_err_left", i, q_err[i].size(), 0);
            cmp("release_left", i, q_rel[i].size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crypto_reg_bank.md
# crypto_reg_bank

Parametrised data-register bank for the cryptographic core: DEPTH registers of WIDTH bits, shared between the core datapath ("core" side) and the system bus ("bus" side). Each side has its own write and read ports. Same-address write collisions are resolved by a fixed, parameter-selected priority. Per-register write locks protect key and state words from bus writes, and bus reads use a hold-until-acknowledged handshake.

## Interface
- WIDTH, 16, register data width
- DEPTH, 8, number of registers (need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width
- BUS_PRIORITY, 1, 1: bus write wins a same-address collision; 0: core write wins
- BYPASS, 0, 1: core read of an address being written this cycle returns the winning write data

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- core_wr_en / core_wr_addr / core_wr_data  in  1/ADDR_W/WIDTH  core write port
- core_rd_en / core_rd_addr  in  1/ADDR_W  core read request
- core_rd_data  out  WIDTH  core read data
- core_rd_valid  out  1  core read data valid, one-cycle pulse
- core_lock_en / core_lock_addr / core_lock_val  in  1/ADDR_W/1  sets or clears one lock bit
- bus_wr_en / bus_wr_addr / bus_wr_data  in  1/ADDR_W/WIDTH  bus write port
- bus_wr_err  out  1  pulse: the bus write was rejected (locked register or out-of-range address)
- bus_rd_req / bus_rd_addr  in  1/ADDR_W  bus read request
- bus_rd_ready  out  1  high in IDLE; a request is accepted only while this is high
- bus_rd_data  out  WIDTH  bus read data, held stable while bus_rd_valid is high
- bus_rd_valid  out  1  bus read data valid, held until acknowledged
- bus_rd_ack  in  1  bus consumes the read data
- wr_collision  out  1  pulse: both sides wrote the same address and one write was dropped

## Operation
- Writes commit on the rising edge. Both ports may write different addresses in the same cycle; both writes commit.
- Same-address collision, with both writes legal:
  - Only the BUS_PRIORITY winner commits.
  - wr_collision pulses for one cycle.
- A locked bus write does not take part in collision resolution, so the core write commits and wr_collision stays 0.
- Locks:
  - lock[a] is set or cleared by core_lock_en.
  - Core writes ignore locks.
  - A bus write to a locked address is dropped and bus_wr_err pulses.
  - A lock update takes effect from the next cycle; a bus write in the same cycle sees the old lock value.
- Out-of-range address (addr >= DEPTH):
  - Writes are ignored.
  - Reads return 0.
  - Bus writes also pulse bus_wr_err.
- Core read:
  - Registered; data appears one cycle after core_rd_en, together with core_rd_valid.
  - BYPASS=0: returns contents before any same-cycle write.
  - BYPASS=1: returns the winning same-cycle write data.
- Bus read state machine:
  - IDLE → HOLD on bus_rd_req with bus_rd_ready=1. The data is captured in that cycle with read-before-write semantics.
  - In HOLD, bus_rd_valid=1 and bus_rd_data is frozen. Later writes to the register do not alter it.
  - HOLD → IDLE on the cycle bus_rd_ack=1.
  - Requests made while in HOLD are ignored, not queued.
- Reset values: all registers 0, all locks 0, every output 0, state IDLE, bus_rd_ready 0 during reset. A reset during HOLD drops the pending read.

## Timing
- Write latency: register updated at edge N when the write is presented in cycle N. A read in cycle N+1 sees the new value.
- wr_collision and bus_wr_err: registered, asserted in cycle N+1 for a write presented in cycle N.
- Core read latency is 1; core_rd_valid is a single-cycle pulse per core_rd_en.
- Bus read: request in cycle N → bus_rd_valid from N+1. If bus_rd_ack is high in cycle M, bus_rd_valid is 0 and bus_rd_ready is 1 in cycle M+1. Minimum request-to-request spacing is 2 cycles.
- bus_rd_ack while bus_rd_valid=0 is ignored.

## Structure
- Shared package crypto_pkg holds the bus-read state encoding (RD_IDLE, RD_HOLD) and the default WIDTH and DEPTH constants.
- One natural sub-module, crypto_wr_arbiter: a combinational block that takes both write requests plus the lock vector and produces per-port commit enables, the collision flag and the error flag. Storage, read ports and the FSM stay in the top module.

## Test plan
- Reset, then a core write of 0xBEEF to address 3 and a core read of 3 → core_rd_data=0xBEEF with core_rd_valid one cycle after the read.
- Same-cycle writes to address 5 (core 0x1111, bus 0x2222), BUS_PRIORITY=1 → reg5=0x2222 and wr_collision pulse. With BUS_PRIORITY=0 → reg5=0x1111.
- Lock address 2, then a bus write of 0xAAAA to address 2 → reg2 unchanged and bus_wr_err pulse. After unlocking, the same write commits.
- Bus read of address 1 (0x00C3), no ack for 5 cycles while the core writes 0xFFFF to address 1 → bus_rd_data holds 0x00C3 and bus_rd_valid stays high. After ack, bus_rd_ready returns the next cycle.
- DEPTH=6: bus write to address 7 → bus_wr_err pulse. Core read of address 7 → 0.
- Assert rst during HOLD → bus_rd_valid drops to 0 immediately, all registers read 0 afterwards, and the FSM is in IDLE.
